// File: rtl/arm_code_emitter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : arm_code_emitter_if                                        |
// | Purpose  : Bundles the producer handshake, base-address load, code    |
// |            memory write port and status signals of the emitter.       |
// | Ports    : start/data/ready     - instruction word handshake          |
// |            base_load/base_addr  - write pointer load                  |
// |            mem_we/mem_addr/mem_wdata/mem_ack - code memory write      |
// |            empty/word_count/overflow - status                         |
// |            modport master: environment side, modport slave: emitter   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface arm_code_emitter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                  start;
   logic [DATA_WIDTH-1:0] data;
   logic                  ready;
   logic                  base_load;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic                  mem_ack;
   logic                  empty;
   logic [ADDR_WIDTH-1:0] word_count;
   logic                  overflow;

   modport master (
      output start, data, base_load, base_addr, mem_ack,
      input  ready, mem_we, mem_addr, mem_wdata, empty, word_count, overflow
   );

   modport slave (
      input  start, data, base_load, base_addr, mem_ack,
      output ready, mem_we, mem_addr, mem_wdata, empty, word_count, overflow
   );
endinterface
`default_nettype wire

// File: rtl/arm_code_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : arm_code_emitter                                           |
// | Purpose  : Buffers translated ARM instruction words in a small FIFO   |
// |            and writes them in order to consecutive word addresses of  |
// |            the output code memory, starting at a loadable base.       |
// | Ports    : clk   - clock, all state changes on rising edge            |
// |            reset - synchronous, active-low                            |
// |            bus   - arm_code_emitter_if.slave (handshake, memory       |
// |                    write port, base load and status)                  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module arm_code_emitter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int DEPTH      = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   arm_code_emitter_if.slave  bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;

   logic [DATA_WIDTH-1:0] fifo_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [0:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic                  overflow_q, overflow_d;

   logic                  ready_w;
   logic                  push_w;
   logic                  pop_w;
   logic                  base_ok_w;

   assign ready_w   = (occ_q != OCC_W'(DEPTH));
   assign push_w    = bus.start & ready_w;
   // mem_ack is only meaningful while a write is being requested
   assign pop_w     = (state_q == S_REQ) & bus.mem_ack;
   assign base_ok_w = bus.base_load & (state_q == S_IDLE) & (occ_q == '0);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q + OCC_W'(push_w) - OCC_W'(pop_w);
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (bus.start & ~ready_w);

      if (push_w) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end

      if (pop_w) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         addr_d   = addr_q + ADDR_WIDTH'(4);
         count_d  = count_q + ADDR_WIDTH'(1);
      end

      // Low two address bits forced to zero to keep writes word-aligned
      if (base_ok_w) begin
         addr_d  = bus.base_addr & ~ADDR_WIDTH'(3);
         count_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            if (occ_q != '0) begin
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            // occ_d already includes a push landing on the popping edge,
            // so streaming continues without an IDLE bubble
            if (pop_w && (occ_d == '0)) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         state_q    <= S_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live
   always_ff @(posedge clk) begin
      if (push_w) begin
         fifo_q[wr_ptr_q] <= bus.data;
      end
   end

   assign bus.ready      = ready_w;
   assign bus.mem_we     = (state_q == S_REQ);
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = fifo_q[rd_ptr_q];
   assign bus.empty      = (occ_q == '0) && (state_q == S_IDLE);
   assign bus.word_count = count_q;
   assign bus.overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_arm_code_emitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_arm_code_emitter                                        |
// | Purpose  : Directed self-checking bench for arm_code_emitter.         |
// |            Inputs change 1 time unit after each rising edge and       |
// |            outputs are sampled at that same point.                    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_arm_code_emitter;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   arm_code_emitter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus_if ();

   arm_code_emitter #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (16),
      .DEPTH      (4)
   ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset              = 1'b0;
      bus_if.start       = 1'b0;
      bus_if.data        = '0;
      bus_if.base_load   = 1'b0;
      bus_if.base_addr   = '0;
      bus_if.mem_ack     = 1'b0;

      // ---------------- reset state ----------------
      step();
      step();
      reset = 1'b1;
      chk("rst_we",       32'(bus_if.mem_we),     32'd0);
      chk("rst_addr",     32'(bus_if.mem_addr),   32'd0);
      chk("rst_count",    32'(bus_if.word_count), 32'd0);
      chk("rst_overflow", 32'(bus_if.overflow),   32'd0);
      chk("rst_empty",    32'(bus_if.empty),      32'd1);
      chk("rst_ready",    32'(bus_if.ready),      32'd1);

      // ---------------- single word ----------------
      bus_if.base_load = 1'b1;
      bus_if.base_addr = 16'h0100;
      step();
      bus_if.base_load = 1'b0;
      chk("t1_base", 32'(bus_if.mem_addr), 32'h0100);
      bus_if.start   = 1'b1;
      bus_if.data    = 32'hE340_0005;
      bus_if.mem_ack = 1'b1;
      step();
      bus_if.start = 1'b0;
      chk("t1_we_lat0", 32'(bus_if.mem_we), 32'd0);
      chk("t1_notempty", 32'(bus_if.empty), 32'd0);
      step();
      chk("t1_we",    32'(bus_if.mem_we),   32'd1);
      chk("t1_addr",  32'(bus_if.mem_addr), 32'h0100);
      chk("t1_wdata", bus_if.mem_wdata,     32'hE340_0005);
      step();
      chk("t1_we_off", 32'(bus_if.mem_we),     32'd0);
      chk("t1_count",  32'(bus_if.word_count), 32'd1);
      chk("t1_empty",  32'(bus_if.empty),      32'd1);
      chk("t1_addr2",  32'(bus_if.mem_addr),   32'h0104);

      // ---------------- fill under stall ----------------
      bus_if.mem_ack   = 1'b0;
      bus_if.base_load = 1'b1;
      bus_if.base_addr = 16'h0100;
      step();
      bus_if.base_load = 1'b0;
      chk("t2_count0", 32'(bus_if.word_count), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("t2_ready_fill", 32'(bus_if.ready), 32'd1);
         bus_if.start = 1'b1;
         bus_if.data  = 32'hA0 + 32'(i);
         step();
      end
      chk("t2_ready_full", 32'(bus_if.ready), 32'd0);
      bus_if.data = 32'hA4;
      step();
      bus_if.start = 1'b0;
      chk("t2_overflow", 32'(bus_if.overflow), 32'd1);
      chk("t2_hold_we",  32'(bus_if.mem_we),   32'd1);
      step();
      chk("t2_hold_data", bus_if.mem_wdata,     32'hA0);
      chk("t2_hold_addr", 32'(bus_if.mem_addr), 32'h0100);
      bus_if.mem_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_drain_we",   32'(bus_if.mem_we),   32'd1);
         chk("t2_drain_data", bus_if.mem_wdata,     32'hA0 + 32'(i));
         chk("t2_drain_addr", 32'(bus_if.mem_addr), 32'h0100 + 32'(4 * i));
         step();
      end
      chk("t2_we_off", 32'(bus_if.mem_we),     32'd0);
      chk("t2_count",  32'(bus_if.word_count), 32'd4);
      chk("t2_empty",  32'(bus_if.empty),      32'd1);

      // ---------------- streaming ----------------
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("t3_ovf_clr", 32'(bus_if.overflow), 32'd0);
      bus_if.base_load = 1'b1;
      bus_if.base_addr = 16'h0200;
      step();
      bus_if.base_load = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus_if.start = 1'b1;
         bus_if.data  = 32'h100 + 32'(i);
         step();
         chk("t3_ready", 32'(bus_if.ready), 32'd1);
         if (i >= 1) begin
            chk("t3_we",    32'(bus_if.mem_we),   32'd1);
            chk("t3_wdata", bus_if.mem_wdata,     32'h100 + 32'(i - 1));
            chk("t3_addr",  32'(bus_if.mem_addr), 32'h0200 + 32'(4 * (i - 1)));
         end
      end
      bus_if.start = 1'b0;
      step();
      chk("t3_last_data", bus_if.mem_wdata,     32'h109);
      chk("t3_last_addr", 32'(bus_if.mem_addr), 32'h0224);
      step();
      chk("t3_we_off",   32'(bus_if.mem_we),     32'd0);
      chk("t3_count",    32'(bus_if.word_count), 32'd10);
      chk("t3_overflow", 32'(bus_if.overflow),   32'd0);

      // ---------------- address wrap ----------------
      bus_if.base_load = 1'b1;
      bus_if.base_addr = 16'hFFFC;
      step();
      bus_if.base_load = 1'b0;
      bus_if.start = 1'b1;
      bus_if.data  = 32'hB0;
      step();
      bus_if.data  = 32'hB1;
      step();
      bus_if.start = 1'b0;
      chk("t4_addr0", 32'(bus_if.mem_addr), 32'hFFFC);
      chk("t4_data0", bus_if.mem_wdata,     32'hB0);
      step();
      chk("t4_addr1", 32'(bus_if.mem_addr), 32'h0000);
      chk("t4_data1", bus_if.mem_wdata,     32'hB1);
      step();
      chk("t4_we_off", 32'(bus_if.mem_we),     32'd0);
      chk("t4_count",  32'(bus_if.word_count), 32'd2);

      // ---------------- base_load while busy ----------------
      bus_if.mem_ack = 1'b0;
      bus_if.start   = 1'b1;
      bus_if.data    = 32'hC0;
      step();
      bus_if.start     = 1'b0;
      bus_if.base_load = 1'b1;
      bus_if.base_addr = 16'h2000;
      step();
      chk("t5_ign_idle", 32'(bus_if.mem_addr), 32'h0004);
      step();
      bus_if.base_load = 1'b0;
      chk("t5_ign_req",  32'(bus_if.mem_addr),   32'h0004);
      chk("t5_ign_cnt",  32'(bus_if.word_count), 32'd2);
      bus_if.mem_ack = 1'b1;
      step();
      chk("t5_seq_addr", 32'(bus_if.mem_addr),   32'h0008);
      chk("t5_empty",    32'(bus_if.empty),      32'd1);
      chk("t5_cnt3",     32'(bus_if.word_count), 32'd3);
      bus_if.base_load = 1'b1;
      step();
      bus_if.base_load = 1'b0;
      chk("t5_load_addr", 32'(bus_if.mem_addr),   32'h2000);
      chk("t5_load_cnt",  32'(bus_if.word_count), 32'd0);

      // ---------------- reset mid-operation ----------------
      bus_if.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus_if.start = 1'b1;
         bus_if.data  = 32'hD0 + 32'(i);
         step();
      end
      bus_if.start = 1'b0;
      chk("t6_we_pre", 32'(bus_if.mem_we), 32'd1);
      bus_if.mem_ack = 1'b1;
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("t6_we",    32'(bus_if.mem_we),     32'd0);
      chk("t6_empty", 32'(bus_if.empty),      32'd1);
      chk("t6_count", 32'(bus_if.word_count), 32'd0);
      chk("t6_addr",  32'(bus_if.mem_addr),   32'h0000);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_no_write", 32'(bus_if.mem_we), 32'd0);
      end
      chk("t6_count_end", 32'(bus_if.word_count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arm_code_emitter.md
# arm_code_emitter

Downstream stage of the JVM-to-ARM translator: it accepts the 32-bit ARM instruction words produced by the translation state machine via a start/ready handshake and buffers them in a small FIFO. It writes them in order into the output code memory at consecutive word addresses, starting from a loadable base. It replaces the single-word writer, so the state machine can keep translating while memory acknowledges slowly.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 16, output memory byte-address width
- DEPTH, 4, FIFO entries; power of two, ≥ 2

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low; one clock; reset is synchronous and active-low
- start  in  1  producer offers `data` this cycle
- data  in  DATA_WIDTH  ARM instruction word
- ready  out  1  FIFO can accept a word this cycle
- base_load  in  1  request to load `base_addr` into the write pointer
- base_addr  in  ADDR_WIDTH  start byte address of emitted code
- mem_we  out  1  write request to code memory
- mem_addr  out  ADDR_WIDTH  byte address of current write
- mem_wdata  out  DATA_WIDTH  word being written (FIFO head)
- mem_ack  in  1  memory accepts the current write this cycle
- empty  out  1  FIFO holds no words and no write is pending
- word_count  out  ADDR_WIDTH  words acknowledged since reset/base_load
- overflow  out  1  sticky: `start` seen while `ready` low

## Operation
- Push: on an edge with start=1 and ready=1, `data` is written at the FIFO tail. ready = (occupancy != DEPTH), combinational from registered occupancy.
- start=1 with ready=0: word dropped, overflow set to 1 at that edge. overflow is cleared only by reset.
- Drain FSM, two states:
  - IDLE: mem_we=0. If occupancy > 0 at an edge, go to REQ.
  - REQ: mem_we=1, mem_wdata = FIFO head, mem_addr = write pointer. On an edge with mem_ack=1: pop the head, add 4 to the write pointer (modulo 2^ADDR_WIDTH, wraps silently), and increment word_count (wraps). Stay in REQ if post-pop occupancy > 0, counting a push on the same edge. Otherwise go to IDLE. With mem_ack=0, hold all outputs stable.
- Push and pop on the same edge: occupancy unchanged, both pointers advance. When full, ready=0, so no push coincides with the pop. ready rises the cycle after the pop.
- base_load: honoured only in IDLE with occupancy 0. It sets the write pointer to {base_addr[ADDR_WIDTH-1:2],2'b00} and clears word_count. It is ignored at all other times, with no other effect.
- empty = (occupancy == 0) && (state == IDLE).
- mem_ack while mem_we=0 is ignored.

## Timing
- Reset (reset=0 at an edge): occupancy 0, pointers 0, state IDLE, write pointer 0. After that edge: mem_we=0, mem_addr=0, word_count=0, overflow=0, empty=1, ready=1. Buffered words are discarded.
- Reset mid-REQ: mem_we drops after that edge, even if mem_ack=1 in the same cycle. No pop, no count.
- Latency, empty FIFO: word pushed at edge N → mem_we=1 with that word from edge N+1.
- Back-to-back: with mem_ack held 1 and the FIFO kept non-empty, one word per cycle, with no IDLE bubble between words.
- Throughput with ack held 1: a sustained push every cycle never drops ready once draining has started.
- mem_wdata/mem_addr are valid only while mem_we=1.

## Test plan
- Reset then single word: base_load with base_addr=0x0100, push 0xE3400005, mem_ack=1 → mem_we high one edge after the push, mem_addr=0x0100, mem_wdata=0xE3400005. word_count=1, empty=1 afterwards.
- Fill under stall: mem_ack=0, push 5 words 0xA0..0xA4 on consecutive cycles → ready=0 after the 4th word, 0xA4 dropped, overflow=1. Then release ack → writes at 0x0100,0x0104,0x0108,0x010C of 0xA0..0xA3, and word_count=4.
- Streaming: push a word every cycle for 10 cycles with mem_ack=1 → mem_we continuously high from the second cycle, 10 ordered writes, ready never low, overflow=0.
- Address wrap: ADDR_WIDTH=16, base_addr=0xFFFC, push 2 words → written at 0xFFFC then 0x0000.
- base_load ignored while busy: FIFO non-empty, base_load with 0x2000 → addresses continue sequentially. A base_load after empty=1 takes effect, and word_count=0.
- Reset mid-operation: 3 words queued, mem_we=1, reset=0 with mem_ack=1 → after the edge mem_we=0, empty=1, word_count=0, and no further writes.
